rv32_bus_responder: RTL and testbench
=====================================

RV32_BUS_RESPONDER -- requirements
Module: rv32_bus_responder

Interface
REQ-001 Parameter DEPTH, default 1024, SHALL be the memory size in 32-bit words; legal values are powers of two from 16 to 65536.
REQ-002 Parameter WAIT_STATES, default 1, SHALL be the number of extra cycles per access; legal range is 0..15.
REQ-003 Parameter INIT_FILE, default "", SHALL name a hex image loaded at elaboration; if empty, memory contents are unspecified.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 instr_address_in  input  32  SHALL carry the instruction fetch byte address.
REQ-007 instr_read_in  input  1  SHALL request an instruction read; the initiator holds it until ready.
REQ-008 instr_read_value_out  output  32  SHALL return the fetched word.
REQ-009 instr_ready_out  output  1  SHALL pulse for one cycle when the instruction read completes.
REQ-010 data_address_in  input  32  SHALL carry the data byte address.
REQ-011 data_read_in / data_write_in  input  1 each  SHALL request a data read or write.
REQ-012 data_write_mask_in  input  4  SHALL carry the byte-lane enables; bit i maps to bits [8i+7:8i].
REQ-013 data_write_value_in  input  32  SHALL carry the write data.
REQ-014 data_read_value_out  output  32  SHALL return the read word.
REQ-015 data_ready_out  output  1  SHALL pulse for one cycle when the data access completes.

Function
REQ-016 Addressing: word index SHALL be address[log2(DEPTH)+1:2]; address bits [1:0] and the bits above the index SHALL be ignored, so out-of-range addresses alias.
REQ-017 The single memory port SHALL be shared through an FSM with states IDLE, BUSY and DONE.
REQ-018 IDLE: when a request is present, the FSM SHALL grant it and latch the granted port's address, strobes, mask and write value. With WAIT_STATES=0 it SHALL go to DONE; otherwise it SHALL go to BUSY with the counter set to WAIT_STATES-1.
REQ-019 Arbitration: if both ports request in the same IDLE cycle, the data port SHALL win; the instruction request stays pending.
REQ-020 BUSY: the counter SHALL decrement each cycle; the FSM SHALL move to DONE in the cycle after the counter reads 0.
REQ-021 DONE: the FSM SHALL assert the granted port's ready_out for exactly one cycle. A read SHALL present the word in that same cycle. A write SHALL commit the masked bytes at the end of that cycle. The FSM SHALL then return to IDLE.
REQ-022 Latency: a request first seen in IDLE at cycle N SHALL get ready in cycle N+1+WAIT_STATES.
REQ-023 No re-accept: the FSM SHALL NOT accept a new request in a DONE cycle. A request held through DONE is treated as new only from the following IDLE cycle.
REQ-024 Abort: if, during BUSY or DONE, the granted port's strobe deasserts or its address, mask or write value differs from the latched copy, the FSM SHALL return to IDLE. No ready SHALL be issued and memory SHALL NOT be written.
REQ-025 data_read_in and data_write_in together SHALL be treated as a write.
REQ-026 A write with mask 4'b0000 SHALL complete normally and change no memory.
REQ-027 read_value outputs SHALL hold their last value when not ready. They are defined only in a ready cycle.
REQ-028 The ready outputs of the two ports SHALL never be high in the same cycle.

Reset
REQ-029 While reset_n=0: the FSM SHALL be in IDLE, the counter SHALL be 0, both ready_out SHALL be 0, both read_value_out SHALL be 32'h0, and any latched grant SHALL be cleared.
REQ-030 Reset asserted mid-access SHALL abandon the access with no memory write. Memory contents SHALL NOT be cleared by reset.
REQ-031 After reset_n deasserts, the first request SHALL be sampled on the first rising edge with reset_n=1.

Verification
REQ-032 Scenario, WAIT_STATES=0: write 32'hDEADBEEF, mask 4'hF, to 0x10 -> data_ready_out in cycle N+1. Then read 0x10 -> data_read_value_out=32'hDEADBEEF with ready in cycle N+1.
REQ-033 Scenario, WAIT_STATES=3: write 32'h11223344 to 0x20. Then write 32'hAABBCCDD to 0x20 with mask 4'b0101. Then read 0x20 -> ready exactly 4 cycles after each request; read value 32'h11BB33DD.
REQ-034 Scenario, contention: instr read 0x0 and data read 0x4 both raised in the same cycle -> data_ready_out first. instr_ready_out follows 2+WAIT_STATES cycles after data ready. The two never overlap.
REQ-035 Scenario, abort, WAIT_STATES=2: data write 0x8 accepted, then data_write_in dropped during BUSY -> no data_ready_out, and a later read of 0x8 returns the prior value. Instr read whose address changes 0x0->0x4 during BUSY -> no ready for 0x0; 0x4 is re-accepted in the next IDLE cycle.
REQ-036 Scenario, aliasing and reset: DEPTH=16, write 32'h5A5A5A5A to 0x40 -> read of 0x0 returns 32'h5A5A5A5A. Then reset_n pulsed low during a BUSY write to 0x0 -> outputs go to reset values immediately and 0x0 still reads 32'h5A5A5A5A.

Source files
------------

// File: rtl/rv32_bus_responder.sv
// Single-port word memory shared between an instruction port and a data port.
// Accesses are serialised by an IDLE/BUSY/DONE FSM with a fixed wait-state count.
module rv32_bus_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr_address_in,
    input  logic        instr_read_in,
    output logic [31:0] instr_read_value_out,
    output logic        instr_ready_out,
    input  logic [31:0] data_address_in,
    input  logic        data_read_in,
    input  logic        data_write_in,
    input  logic [3:0]  data_write_mask_in,
    input  logic [31:0] data_write_value_in,
    output logic [31:0] data_read_value_out,
    output logic        data_ready_out
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic          gnt_data_q;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [3:0]    mask_q;
    logic [31:0]   wdata_q;
    logic [31:0]   instr_rdata_q;
    logic [31:0]   data_rdata_q;
    logic [31:0]   mem [DEPTH];

    logic          data_req;
    logic          data_hit;
    logic          instr_hit;
    logic          hit;
    logic [AW-1:0] req_idx;
    logic [AW-1:0] cur_idx;

    assign data_req = data_read_in | data_write_in;
    assign req_idx  = data_req ? data_address_in[AW+1:2] : instr_address_in[AW+1:2];
    assign cur_idx  = addr_q[AW+1:2];

    // The granted port must keep presenting exactly what was latched, else the access is dropped.
    assign data_hit  = gnt_data_q
                       && (data_address_in == addr_q)
                       && (data_write_mask_in == mask_q)
                       && (data_write_value_in == wdata_q)
                       && (we_q ? data_write_in : (data_read_in && !data_write_in));
    assign instr_hit = !gnt_data_q && instr_read_in && (instr_address_in == addr_q);
    assign hit       = data_hit || instr_hit;

    assign data_ready_out       = (state_q == DONE) && data_hit;
    assign instr_ready_out      = (state_q == DONE) && instr_hit;
    assign data_read_value_out  = data_rdata_q;
    assign instr_read_value_out = instr_rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            gnt_data_q    <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= 32'h0;
            mask_q        <= 4'h0;
            wdata_q       <= 32'h0;
            instr_rdata_q <= 32'h0;
            data_rdata_q  <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (data_req || instr_read_in) begin
                        gnt_data_q <= data_req;
                        we_q       <= data_req && data_write_in;
                        addr_q     <= data_req ? data_address_in : instr_address_in;
                        mask_q     <= data_write_mask_in;
                        wdata_q    <= data_write_value_in;
                        if (WAIT_STATES == 0) begin
                            state_q <= DONE;
                            if (!data_req)           instr_rdata_q <= mem[req_idx];
                            else if (!data_write_in) data_rdata_q  <= mem[req_idx];
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                BUSY: begin
                    if (!hit) begin
                        state_q <= IDLE;
                    end else if (cnt_q == 4'd0) begin
                        state_q <= DONE;
                        if (!gnt_data_q) instr_rdata_q <= mem[cur_idx];
                        else if (!we_q)  data_rdata_q  <= mem[cur_idx];
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Memory is deliberately outside the reset domain; writes commit only on a clean DONE.
    always_ff @(posedge clk) begin
        if ((state_q == DONE) && data_hit && we_q) begin
            for (int b = 0; b < 4; b++) begin
                if (mask_q[b]) mem[cur_idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_rv32_bus_responder.sv
// Directed bench: instance 0 has zero wait states, instance 1 is a 16-word memory with 3 wait states.
module tb_rv32_bus_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [31:0] i_addr [2];
    logic        i_rd   [2];
    logic [31:0] i_rv   [2];
    logic        i_rdy  [2];
    logic [31:0] d_addr [2];
    logic        d_rd   [2];
    logic        d_wr   [2];
    logic [3:0]  d_mask [2];
    logic [31:0] d_wv   [2];
    logic [31:0] d_rv   [2];
    logic        d_rdy  [2];

    int tests = 0;
    int fails = 0;

    rv32_bus_responder #(.DEPTH(1024), .WAIT_STATES(0), .INIT_FILE("")) u_ws0 (
        .clk(clk), .reset_n(reset_n),
        .instr_address_in(i_addr[0]), .instr_read_in(i_rd[0]),
        .instr_read_value_out(i_rv[0]), .instr_ready_out(i_rdy[0]),
        .data_address_in(d_addr[0]), .data_read_in(d_rd[0]), .data_write_in(d_wr[0]),
        .data_write_mask_in(d_mask[0]), .data_write_value_in(d_wv[0]),
        .data_read_value_out(d_rv[0]), .data_ready_out(d_rdy[0])
    );

    rv32_bus_responder #(.DEPTH(16), .WAIT_STATES(3), .INIT_FILE("")) u_ws3 (
        .clk(clk), .reset_n(reset_n),
        .instr_address_in(i_addr[1]), .instr_read_in(i_rd[1]),
        .instr_read_value_out(i_rv[1]), .instr_ready_out(i_rdy[1]),
        .data_address_in(d_addr[1]), .data_read_in(d_rd[1]), .data_write_in(d_wr[1]),
        .data_write_mask_in(d_mask[1]), .data_write_value_in(d_wv[1]),
        .data_read_value_out(d_rv[1]), .data_ready_out(d_rdy[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds the request through the ready cycle, then releases it in the following IDLE cycle.
    task automatic data_acc(input int k, input logic wr, input logic rd, input logic [31:0] a,
                            input logic [3:0] m, input logic [31:0] wv,
                            output logic [31:0] rv, output int lat);
        d_addr[k] = a; d_wr[k] = wr; d_rd[k] = rd; d_mask[k] = m; d_wv[k] = wv;
        lat = -1;
        rv  = 32'h0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (d_rdy[k]) begin
                lat = c;
                rv  = d_rv[k];
                break;
            end
        end
        tick();
        d_wr[k] = 1'b0;
        d_rd[k] = 1'b0;
    endtask

    task automatic instr_acc(input int k, input logic [31:0] a, output logic [31:0] rv, output int lat);
        i_addr[k] = a; i_rd[k] = 1'b1;
        lat = -1;
        rv  = 32'h0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (i_rdy[k]) begin
                lat = c;
                rv  = i_rv[k];
                break;
            end
        end
        tick();
        i_rd[k] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rv, dv, iv;
        int          lat, td, ti;
        logic        ovl, seen;

        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            i_addr[k] = 32'h0; i_rd[k] = 1'b0;
            d_addr[k] = 32'h0; d_rd[k] = 1'b0; d_wr[k] = 1'b0;
            d_mask[k] = 4'h0;  d_wv[k] = 32'h0;
        end
        repeat (2) tick();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset ready[%0d]", k), {62'h0, i_rdy[k], d_rdy[k]}, 64'h0);
            check($sformatf("reset rdata[%0d]", k), {i_rv[k], d_rv[k]}, 64'h0);
        end
        reset_n = 1'b1;
        tick();

        // Zero wait states
        data_acc(0, 1'b1, 1'b0, 32'h10, 4'hF, 32'hDEADBEEF, rv, lat);
        check("ws0 write lat", 64'(lat), 64'd1);
        data_acc(0, 1'b0, 1'b1, 32'h10, 4'h0, 32'h0, rv, lat);
        check("ws0 read lat", 64'(lat), 64'd1);
        check("ws0 read val", 64'(rv), 64'hDEADBEEF);
        data_acc(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, rv, lat);
        check("ws0 mask0 lat", 64'(lat), 64'd1);
        data_acc(0, 1'b0, 1'b1, 32'h10, 4'h0, 32'h0, rv, lat);
        check("ws0 mask0 keeps", 64'(rv), 64'hDEADBEEF);
        data_acc(0, 1'b1, 1'b1, 32'h14, 4'hF, 32'h01020304, rv, lat);
        check("ws0 rd+wr lat", 64'(lat), 64'd1);
        data_acc(0, 1'b0, 1'b1, 32'h14, 4'h0, 32'h0, rv, lat);
        check("ws0 rd+wr is write", 64'(rv), 64'h01020304);
        instr_acc(0, 32'h12, rv, lat);
        check("ws0 instr lat", 64'(lat), 64'd1);
        check("ws0 instr val", 64'(rv), 64'hDEADBEEF);

        // Three wait states, masked write
        data_acc(1, 1'b1, 1'b0, 32'h20, 4'hF, 32'h11223344, rv, lat);
        check("ws3 write lat", 64'(lat), 64'd4);
        data_acc(1, 1'b1, 1'b0, 32'h20, 4'b0101, 32'hAABBCCDD, rv, lat);
        check("ws3 masked write lat", 64'(lat), 64'd4);
        data_acc(1, 1'b0, 1'b1, 32'h20, 4'h0, 32'h0, rv, lat);
        check("ws3 read lat", 64'(lat), 64'd4);
        check("ws3 masked read val", 64'(rv), 64'h11BB33DD);

        data_acc(1, 1'b1, 1'b0, 32'h0, 4'hF, 32'hA0A0A0A0, rv, lat);
        data_acc(1, 1'b1, 1'b0, 32'h4, 4'hF, 32'hB4B4B4B4, rv, lat);

        // Contention: data port wins, instruction follows
        i_addr[1] = 32'h0; i_rd[1] = 1'b1;
        d_addr[1] = 32'h4; d_rd[1] = 1'b1; d_mask[1] = 4'h0; d_wv[1] = 32'h0;
        td = -1; ti = -1; ovl = 1'b0; dv = 32'h0; iv = 32'h0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (td > 0 && c == td + 1) d_rd[1] = 1'b0;
            if (ti > 0 && c == ti + 1) break;
            if (d_rdy[1] && i_rdy[1]) ovl = 1'b1;
            if (d_rdy[1] && td < 0) begin td = c; dv = d_rv[1]; end
            if (i_rdy[1] && ti < 0) begin ti = c; iv = i_rv[1]; end
        end
        i_rd[1] = 1'b0;
        d_rd[1] = 1'b0;
        check("contend data lat", 64'(td), 64'd4);
        check("contend data val", 64'(dv), 64'hB4B4B4B4);
        check("contend instr gap", 64'(ti - td), 64'd5);
        check("contend instr val", 64'(iv), 64'hA0A0A0A0);
        check("contend overlap", 64'(ovl), 64'd0);

        // Abort: write strobe dropped during BUSY
        data_acc(1, 1'b1, 1'b0, 32'h8, 4'hF, 32'h12345678, rv, lat);
        d_addr[1] = 32'h8; d_wr[1] = 1'b1; d_mask[1] = 4'hF; d_wv[1] = 32'hFFFFFFFF;
        seen = d_rdy[1];
        tick();
        seen = seen | d_rdy[1];
        tick();
        seen = seen | d_rdy[1];
        d_wr[1] = 1'b0;
        repeat (8) begin
            tick();
            seen = seen | d_rdy[1];
        end
        check("abort write no ready", 64'(seen), 64'd0);
        data_acc(1, 1'b0, 1'b1, 32'h8, 4'h0, 32'h0, rv, lat);
        check("abort write mem kept", 64'(rv), 64'h12345678);

        // Abort: instruction address changes during BUSY, new address re-accepted
        i_addr[1] = 32'h0; i_rd[1] = 1'b1;
        lat = -1; iv = 32'h0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 2) i_addr[1] = 32'h4;
            if (i_rdy[1]) begin
                lat = c;
                iv  = i_rv[1];
                break;
            end
        end
        tick();
        i_rd[1] = 1'b0;
        check("abort instr lat", 64'(lat), 64'd7);
        check("abort instr val", 64'(iv), 64'hB4B4B4B4);

        // Aliasing in a 16-word memory
        data_acc(1, 1'b1, 1'b0, 32'h40, 4'hF, 32'h5A5A5A5A, rv, lat);
        check("alias write lat", 64'(lat), 64'd4);
        data_acc(1, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0, rv, lat);
        check("alias read val", 64'(rv), 64'h5A5A5A5A);

        // Reset in the middle of a BUSY write
        d_addr[1] = 32'h0; d_wr[1] = 1'b1; d_mask[1] = 4'hF; d_wv[1] = 32'h0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("midreset ready", {62'h0, i_rdy[1], d_rdy[1]}, 64'h0);
        check("midreset rdata", {i_rv[1], d_rv[1]}, 64'h0);
        check("midreset rdata ws0", {i_rv[0], d_rv[0]}, 64'h0);
        d_wr[1] = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        data_acc(1, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0, rv, lat);
        check("post reset lat", 64'(lat), 64'd4);
        check("post reset mem kept", 64'(rv), 64'h5A5A5A5A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
